game_flow_fsm: RTL and testbench

Central game-flow controller for the Frogger design. It sits between FrogController and LevelCounter/VgaDisplay. It consumes the frog's collision and reached-top events plus the debounced start combo. It owns the level, lives, freeze and death/level-up animation phases, and drives the frog-reset pulse and the BCD level digits for the seven-segment decoders.

---
 rtl/frogger_pkg.sv | 32 +++
 rtl/phase_timer.sv | 53 +++++
 rtl/game_flow_fsm.sv | 149 ++++++++++++++
 tb/tb_game_flow_fsm.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared Frogger types, widths and default timing constants.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package frogger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DEATH     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_t;

    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 4;

    // Default timing at the 25 MHz pixel clock; shared with VgaDisplay/LevelCounter.
    localparam int DEF_START_LIVES     = 3;
    localparam int DEF_MAX_LEVEL       = 15;
    localparam int DEF_DEATH_CYCLES    = 25_000_000;
    localparam int DEF_LEVEL_UP_CYCLES = 12_500_000;
    localparam int DEF_FLASH_HALF      = 3_125_000;

    // Level is at most 15, so the tens digit is only ever 0 or 1.
    function automatic logic [7:0] level_to_bcd(input logic [LEVEL_W-1:0] lvl);
        if (lvl >= 4'd10) begin
            return {4'd1, lvl - 4'd10};
        end
        return {4'd0, lvl};
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable phase down-counter with a zero flag and a half-period blink output.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts every cycle until it reaches zero and then holds.
module phase_timer #(
    parameter int CNT_W      = 3,
    parameter int FLASH_HALF = 1
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done,
    output logic             flash
);

    localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FLASH_W-1:0] FLASH_RELOAD = FLASH_W'(FLASH_HALF - 1);

    logic [CNT_W-1:0]   cnt_q;
    logic [FLASH_W-1:0] fcnt_q;
    logic               flash_q;

    // Phase count: reload on entry, then count down and park at zero.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Blink: starts high on every load and inverts each FLASH_HALF cycles.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            fcnt_q  <= '0;
            flash_q <= 1'b0;
        end else if (load) begin
            fcnt_q  <= FLASH_RELOAD;
            flash_q <= 1'b1;
        end else if (fcnt_q == '0) begin
            fcnt_q  <= FLASH_RELOAD;
            flash_q <= ~flash_q;
        end else begin
            fcnt_q  <= fcnt_q - 1'b1;
        end
    end

    assign done  = (cnt_q == '0);
    assign flash = flash_q;

endmodule

// File: rtl/game_flow_fsm.sv
// Frogger game-flow controller: level, lives, freeze and death/level-up phases.
// Latency: one clock from a sampled input rising edge to new state/level/lives.
// Backpressure: none; events arriving outside PLAY (except start) are dropped.
module game_flow_fsm
    import frogger_pkg::*;
#(
    parameter int START_LIVES     = DEF_START_LIVES,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
    parameter int DEATH_CYCLES    = DEF_DEATH_CYCLES,
    parameter int LEVEL_UP_CYCLES = DEF_LEVEL_UP_CYCLES,
    parameter int FLASH_HALF      = DEF_FLASH_HALF
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Start,
    input  logic               i_Collision,
    input  logic               i_Frog_At_Top,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Reset_Frog,
    output logic               o_Freeze,
    output logic               o_Flash,
    output logic               o_Game_Over,
    output logic [3:0]         o_Level_Tens,
    output logic [3:0]         o_Level_Units
);

    localparam int TMR_MAX = (DEATH_CYCLES > LEVEL_UP_CYCLES) ? DEATH_CYCLES : LEVEL_UP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0]   DEATH_RELOAD = TMR_W'(DEATH_CYCLES - 1);
    localparam logic [TMR_W-1:0]   LVLUP_RELOAD = TMR_W'(LEVEL_UP_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] MAX_LVL      = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0] INIT_LIVES   = LIVES_W'(START_LIVES);

    game_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               reset_frog_q, reset_frog_d;
    logic               start_prev_q, col_prev_q, top_prev_q;
    logic               start_evt, col_evt, top_evt;
    logic               tmr_load, tmr_done, tmr_flash;
    logic [TMR_W-1:0]   tmr_val;

    // Edge history resets high so a level already asserted at reset release is not an event.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            start_prev_q <= 1'b1;
            col_prev_q   <= 1'b1;
            top_prev_q   <= 1'b1;
        end else begin
            start_prev_q <= i_Start;
            col_prev_q   <= i_Collision;
            top_prev_q   <= i_Frog_At_Top;
        end
    end

    assign start_evt = i_Start & ~start_prev_q;
    assign col_evt   = i_Collision & ~col_prev_q;
    assign top_evt   = i_Frog_At_Top & ~top_prev_q;

    // State, score registers and the registered frog-reset pulse.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            level_q      <= LEVEL_W'(1);
            lives_q      <= INIT_LIVES;
            reset_frog_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            reset_frog_q <= reset_frog_d;
        end
    end

    // Next-state: start beats collision beats at-top; phases only exit on timer expiry.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        reset_frog_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = DEATH_RELOAD;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_evt) begin
                    state_d      = ST_PLAY;
                    level_d      = LEVEL_W'(1);
                    lives_d      = INIT_LIVES;
                    reset_frog_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (start_evt) begin
                    state_d      = ST_PLAY;
                    level_d      = LEVEL_W'(1);
                    lives_d      = INIT_LIVES;
                    reset_frog_d = 1'b1;
                end else if (col_evt) begin
                    tmr_load = 1'b1;
                    tmr_val  = DEATH_RELOAD;
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        state_d = ST_DEATH;
                    end
                end else if (top_evt) begin
                    tmr_load = 1'b1;
                    tmr_val  = LVLUP_RELOAD;
                    state_d  = ST_LEVEL_UP;
                    level_d  = (level_q >= MAX_LVL) ? MAX_LVL : level_q + 1'b1;
                end
            end
            ST_DEATH, ST_LEVEL_UP: begin
                if (tmr_done) begin
                    state_d      = ST_PLAY;
                    reset_frog_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    phase_timer #(
        .CNT_W      (TMR_W),
        .FLASH_HALF (FLASH_HALF)
    ) u_phase_timer (
        .core_clk (i_Clk),
        .arst_n   (i_Rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .flash    (tmr_flash)
    );

    assign o_Level      = level_q;
    assign o_Lives      = lives_q;
    assign o_Reset_Frog = reset_frog_q;
    assign o_Freeze     = (state_q != ST_PLAY);
    assign o_Flash      = tmr_flash & ((state_q == ST_DEATH) | (state_q == ST_GAME_OVER));
    assign o_Game_Over  = (state_q == ST_GAME_OVER);
    assign {o_Level_Tens, o_Level_Units} = level_to_bcd(level_q);

endmodule

// File: tb/tb_game_flow_fsm.sv
// Self-checking bench for game_flow_fsm with short phase lengths.
// Latency: outputs sampled on the falling edge after each driven rising edge.
// Backpressure: n/a.
module tb_game_flow_fsm;

    typedef struct packed {
        logic [3:0] level;
        logic [1:0] lives;
        logic       rf;
        logic       frz;
        logic       fl;
        logic       go;
        logic [3:0] tens;
        logic [3:0] units;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       col = 1'b0;
    logic       top = 1'b0;
    logic [3:0] level;
    logic [1:0] lives;
    logic       reset_frog, freeze, flash, game_over;
    logic [3:0] tens, units;
    out_t       obs;

    int   n_cmp  = 0;
    int   n_fail = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    game_flow_fsm #(
        .START_LIVES     (3),
        .MAX_LEVEL       (15),
        .DEATH_CYCLES    (8),
        .LEVEL_UP_CYCLES (4),
        .FLASH_HALF      (2)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Start       (start),
        .i_Collision   (col),
        .i_Frog_At_Top (top),
        .o_Level       (level),
        .o_Lives       (lives),
        .o_Reset_Frog  (reset_frog),
        .o_Freeze      (freeze),
        .o_Flash       (flash),
        .o_Game_Over   (game_over),
        .o_Level_Tens  (tens),
        .o_Level_Units (units)
    );

    assign obs = {level, lives, reset_frog, freeze, flash, game_over, tens, units};

    function automatic out_t mk(input int lvl, input int lv, input bit rf, input bit frz,
                                input bit fl, input bit go);
        out_t r;
        r.level = 4'(lvl);
        r.lives = 2'(lv);
        r.rf    = rf;
        r.frz   = frz;
        r.fl    = fl;
        r.go    = go;
        r.tens  = 4'(lvl / 10);
        r.units = 4'(lvl % 10);
        return r;
    endfunction

    task automatic test_reset();
        out_t e;
        rst_n = 1'b0;
        start = 1'b1;
        col   = 1'b0;
        top   = 1'b0;
        exp_q.push_back(mk(1, 3, 0, 1, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, e);
        end
        rst_n = 1'b1;
        exp_q.push_back(mk(1, 3, 0, 1, 0, 0));
        @(negedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL start_held_at_release: got %h expected %h", obs, e);
        end
        start = 1'b0;
        exp_q.push_back(mk(1, 3, 0, 1, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL idle_wait: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_start();
        out_t e;
        start = 1'b1;
        exp_q.push_back(mk(1, 3, 1, 0, 0, 0));
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL start_edge: got %h expected %h", obs, e);
        end
        exp_q.push_back(mk(1, 3, 0, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL start_pulse_end: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_death();
        out_t e;
        col = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(1, 2, 0, 1, ((k / 2) % 2) == 0, 0));
            @(negedge clk);
            col = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL death_cycle%0d: got %h expected %h", k, obs, e);
            end
        end
        exp_q.push_back(mk(1, 2, 1, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL death_exit: got %h expected %h", obs, e);
        end
        exp_q.push_back(mk(1, 2, 0, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL death_back_in_play: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_game_over();
        out_t e;
        start = 1'b1;
        exp_q.push_back(mk(1, 3, 1, 0, 0, 0));
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL go_restart_in_play: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            col = 1'b1;
            exp_q.push_back(mk(1, 2 - i, 0, 1, 1, i == 2));
            @(negedge clk);
            col = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL go_collision%0d: got %h expected %h", i, obs, e);
            end
            if (i < 2) begin
                repeat (7) @(negedge clk);
                exp_q.push_back(mk(1, 2 - i, 1, 0, 0, 0));
                @(negedge clk);
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL go_death_exit%0d: got %h expected %h", i, obs, e);
                end
            end
        end
        col = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 1, 1, 1));
        @(negedge clk);
        col = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL go_ignore_collision: got %h expected %h", obs, e);
        end
        exp_q.push_back(mk(1, 0, 0, 1, 0, 1));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL go_flash_low: got %h expected %h", obs, e);
        end
        start = 1'b1;
        exp_q.push_back(mk(1, 3, 1, 0, 0, 0));
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL go_new_game: got %h expected %h", obs, e);
        end
        exp_q.push_back(mk(1, 3, 0, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL go_new_game_play: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_level_up();
        out_t e;
        int   lvl;
        for (int i = 0; i < 15; i++) begin
            lvl = (i + 2 > 15) ? 15 : i + 2;
            top = 1'b1;
            exp_q.push_back(mk(lvl, 3, 0, 1, 0, 0));
            @(negedge clk);
            top = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL levelup_entry%0d: got %h expected %h", i, obs, e);
            end
            repeat (3) @(negedge clk);
            exp_q.push_back(mk(lvl, 3, 1, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL levelup_exit%0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        out_t e;
        col = 1'b1;
        top = 1'b1;
        exp_q.push_back(mk(15, 2, 0, 1, 1, 0));
        @(negedge clk);
        top = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL simultaneous_edges: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_collision_held();
        out_t e;
        repeat (7) @(negedge clk);
        exp_q.push_back(mk(15, 2, 1, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL held_exit: got %h expected %h", obs, e);
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(15, 2, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL held_no_event%0d: got %h expected %h", k, obs, e);
            end
        end
        col = 1'b0;
    endtask

    task automatic test_reset_mid_phase();
        out_t e;
        top = 1'b1;
        exp_q.push_back(mk(15, 2, 0, 1, 0, 0));
        @(negedge clk);
        top = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL midphase_entry: got %h expected %h", obs, e);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.push_back(mk(1, 3, 0, 1, 0, 0));
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(1, 3, 0, 1, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_death();
        test_game_over();
        test_level_up();
        test_simultaneous();
        test_collision_held();
        test_reset_mid_phase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
